// File: rtl/fifo_stream_reader_if.sv
// FIFO read-port plus valid/ready stream bundle for fifo_stream_reader.
// The master modport is the reader side; slave is the FIFO and consumer side.
interface fifo_stream_reader_if #(
  parameter int unsigned C_WIDTH = 32
);
  logic               FIFO_RD_EN;
  logic [C_WIDTH-1:0] FIFO_RD_DATA;
  logic               FIFO_EMPTY;
  logic [C_WIDTH-1:0] OUT_DATA;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [1:0]         COUNT;

  modport master (
    output FIFO_RD_EN, OUT_DATA, OUT_VALID, COUNT,
    input  FIFO_RD_DATA, FIFO_EMPTY, OUT_READY
  );

  modport slave (
    input  FIFO_RD_EN, OUT_DATA, OUT_VALID, COUNT,
    output FIFO_RD_DATA, FIFO_EMPTY, OUT_READY
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-EMPTY synchronous FIFO into a registered valid/ready stream.
// Two output slots plus one tracked in-flight read give full throughput under stalls.
module fifo_stream_reader #(
  parameter int unsigned C_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   CLEAR,
  fifo_stream_reader_if.master   bus
);

  logic [C_WIDTH-1:0] slot0_q, slot0_d;
  logic [C_WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]         count_q, count_d;
  logic               inflight_q, inflight_d;
  logic               valid_q, valid_d;

  logic               pop;
  logic [2:0]         occupancy;
  logic               rd_en;
  logic [1:0]         wr_idx;

  always_comb begin
    pop        = (count_q != 2'd0) && bus.OUT_READY;
    // Slots committed after this edge, counting the word already in flight.
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en      = RST_N && !CLEAR && !bus.FIFO_EMPTY && (occupancy < 3'd2);
    wr_idx     = count_q - {1'b0, pop};

    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    count_d    = count_q;
    inflight_d = rd_en;

    if (CLEAR) begin
      count_d = '0;
    end else begin
      if (pop) begin
        slot0_d = slot1_q;
      end
      if (inflight_q) begin
        if (wr_idx == 2'd0) begin
          slot0_d = bus.FIFO_RD_DATA;
        end else begin
          slot1_d = bus.FIFO_RD_DATA;
        end
      end
      count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.FIFO_RD_EN = rd_en;
  assign bus.OUT_DATA   = slot0_q;
  assign bus.OUT_VALID  = valid_q;
  assign bus.COUNT      = count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomised checks of fifo_stream_reader against a behavioural
// registered-EMPTY FIFO and an in-order scoreboard.
module tb_fifo_stream_reader;

  logic        CLK;
  logic        RST_N;
  logic        CLEAR;
  logic        wr_en;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int rd_cnt   = 0;
  bit rnd_mon  = 0;

  logic [31:0] fq[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  logic [31:0] exp_q[$];

  fifo_stream_reader_if #(.C_WIDTH(32)) bus ();

  fifo_stream_reader #(.C_WIDTH(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLEAR (CLEAR),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Synchronous FIFO: RD_DATA valid the cycle after a read, EMPTY registered.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fq.delete();
      bus.FIFO_EMPTY   <= 1'b1;
      bus.FIFO_RD_DATA <= '0;
    end else begin
      if (bus.FIFO_RD_EN && fq.size() > 0) bus.FIFO_RD_DATA <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      bus.FIFO_EMPTY <= (fq.size() == 0);
    end
  end

  always @(negedge CLK) begin
    if (bus.OUT_VALID && bus.OUT_READY) begin
      got_data.push_back(bus.OUT_DATA);
      got_cyc.push_back(cyc);
    end
    if (bus.FIFO_RD_EN) rd_cnt++;
    if (rnd_mon) begin
      chk("count_le2", {31'd0, bus.COUNT <= 2'd2}, 32'd1);
      chk("rd_en_while_empty", {31'd0, bus.FIFO_RD_EN & bus.FIFO_EMPTY}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N         = 1'b0;
    CLEAR         = 1'b0;
    wr_en         = 1'b0;
    wr_data       = '0;
    bus.OUT_READY = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    got_data.delete();
    got_cyc.delete();
    rd_cnt = 0;
  endtask

  task automatic write_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 32'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Writes n consecutive words with OUT_READY high; checks latency and gap-free delivery.
  task automatic stream_measure(input string tag, input logic [31:0] base, input int n);
    int t_empty;
    int t_valid;
    t_empty = -1;
    t_valid = -1;
    got_data.delete();
    got_cyc.delete();
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < n + 20; c++) begin
      wr_en   = (c < n);
      wr_data = base + 32'(c);
      @(negedge CLK);
      if (!bus.FIFO_EMPTY && t_empty < 0) t_empty = c;
      if (bus.OUT_VALID && t_valid < 0) t_valid = c;
      @(posedge CLK);
      #1;
    end
    wr_en = 1'b0;
    chk({tag, "_latency"}, 32'(t_valid - t_empty), 32'd2);
    chk({tag, "_beats"}, 32'(got_data.size()), 32'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      chk({tag, "_data"}, got_data[i], base + 32'(i));
      chk({tag, "_gap"}, 32'(got_cyc[i] - got_cyc[0]), 32'(i));
    end
  endtask

  initial begin
    int sent;
    int guard;

    RST_N = 1'b0;
    CLEAR = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    bus.OUT_READY = 1'b0;
    #2;
    chk("rst_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("rst_data", bus.OUT_DATA, 32'd0);
    chk("rst_count", {30'd0, bus.COUNT}, 32'd0);
    chk("rst_rd_en", {31'd0, bus.FIFO_RD_EN}, 32'd0);

    // Streaming 0x0..0xF
    do_reset();
    stream_measure("stream", 32'h0, 16);

    // Stall: 8 words queued, consumer held off
    do_reset();
    write_words(32'h0, 8);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("stall_valid", {31'd0, bus.OUT_VALID}, 32'd1);
      chk("stall_data", bus.OUT_DATA, 32'h0);
      @(posedge CLK);
      #1;
    end
    chk("stall_rd_pulses", 32'(rd_cnt), 32'd2);
    chk("stall_count", {30'd0, bus.COUNT}, 32'd2);
    got_data.delete();
    got_cyc.delete();
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    chk("release_beats", 32'(got_data.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      chk("release_data", got_data[i], 32'(i));
      chk("release_gap", 32'(got_cyc[i] - got_cyc[0]), 32'(i));
    end

    // Random backpressure with scoreboard
    do_reset();
    exp_q.delete();
    rnd_mon = 1;
    sent = 0;
    guard = 0;
    while ((got_data.size() < 1000) && (guard < 20000)) begin
      if (sent < 1000 && ($urandom % 4) != 0) begin
        wr_en   = 1'b1;
        wr_data = $urandom;
        exp_q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      bus.OUT_READY = $urandom_range(0, 1);
      tick();
      guard++;
    end
    wr_en = 1'b0;
    rnd_mon = 0;
    chk("rand_beats", 32'(got_data.size()), 32'd1000);
    for (int i = 0; i < 1000 && i < got_data.size(); i++) chk("rand_order", got_data[i], exp_q[i]);

    // Flush with one word popped, one held and one in flight
    do_reset();
    write_words(32'h100, 8);
    for (int c = 0; c < 4; c++) tick();
    @(negedge CLK);
    chk("flush_pre_count", {30'd0, bus.COUNT}, 32'd2);
    @(posedge CLK);
    #1;
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
    CLEAR = 1'b1;
    @(negedge CLK);
    chk("flush_hold_count", {30'd0, bus.COUNT}, 32'd1);
    chk("flush_rd_en", {31'd0, bus.FIFO_RD_EN}, 32'd0);
    @(posedge CLK);
    #1;
    CLEAR = 1'b0;
    @(negedge CLK);
    chk("flush_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("flush_count", {30'd0, bus.COUNT}, 32'd0);
    chk("flush_first_popped", (got_data.size() > 0) ? got_data[0] : 32'hDEAD, 32'h100);
    @(posedge CLK);
    #1;
    got_data.delete();
    got_cyc.delete();
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    chk("flush_beats", 32'(got_data.size()), 32'd5);
    if (got_data.size() >= 2) begin
      chk("flush_next0", got_data[0], 32'h103);
      chk("flush_next1", got_data[1], 32'h104);
    end else begin
      chk("flush_next_missing", 32'(got_data.size()), 32'd2);
    end

    // Asynchronous reset mid-stream
    do_reset();
    bus.OUT_READY = 1'b1;
    write_words(32'h200, 8);
    chk("mid_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("async_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("async_count", {30'd0, bus.COUNT}, 32'd0);
    chk("async_rd_en", {31'd0, bus.FIFO_RD_EN}, 32'd0);
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    stream_measure("post_rst", 32'hA5, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
